phy_tx_lane_striper: RTL and testbench
======================================

Name: phy_tx_lane_striper

Overview:
Transmit-side counterpart of the two-lane PHY receiver. Accepts 32-bit words from the link layer through a valid/ready handshake and buffers them in a small FIFO. Stripes each word across two 8-bit lanes over two clock cycles. After reset it emits a COM training burst so the receiver can align, then sends data bytes or IDLE symbols.

Parameters:
FIFO_DEPTH, 4, number of 32-bit words buffered; power of two, minimum 2.
SYNC_COUNT, 8, cycles of COM emitted after reset release before ACTIVE.
COM_SYM, 8'hBC, training/alignment symbol (K28.5 code).
IDLE_SYM, 8'h7C, filler symbol sent when no data is available.

Ports:
clk_2f  input  1  single clock; all state updates on rising edge.
reset  input  1  asynchronous, active-low; 0 clears all state immediately.
data_in  input  32  word from link layer.
valid_in  input  1  data_in valid.
ready_out  output  1  block can accept a word this cycle.
data_out_0  output  8  lane 0 byte.
data_out_1  output  8  lane 1 byte.
valid_out_0  output  1  lane 0 byte is data or training (not idle).
valid_out_1  output  1  lane 1 byte is data or training (not idle).
active_out  output  1  1 once training is complete (ACTIVE state).

Behaviour:
- Reset is asynchronous and active-low: while reset=0, the FSM goes to SYNC, FIFO pointers, count and sync counter clear, data_out_0/1=8'h00, valid_out_0/1=0, active_out=0.
- Handshake: a word is accepted at a rising edge when valid_in=1 and ready_out=1.
- ready_out is combinational and equals (fifo_count != FIFO_DEPTH). It is 1 in reset and in SYNC, so words accepted during SYNC are held.
- ready_out depends only on the current count. A pop in the same cycle does not free space for that cycle's push.
- FIFO: circular buffer, wr/rd pointers wrap modulo FIFO_DEPTH. Simultaneous push and pop leave the count unchanged. No bypass: a word pushed at edge E is poppable at E+1 at the earliest.
- All lane outputs are registered.
- FSM states:
  - SYNC: each cycle drives COM_SYM on both lanes with valid_out_0/1=1 and increments sync_cnt. After SYNC_COUNT cycles of COM the next state is ACTIVE_HI.
  - ACTIVE_HI: if the FIFO is non-empty, pop the word into a hold register. Drive data_out_0=word[31:24], data_out_1=word[23:16], valid=1, and go to ACTIVE_LO. If the FIFO is empty, drive IDLE_SYM on both lanes with valid=0 and stay.
  - ACTIVE_LO: drive data_out_0=hold[15:8], data_out_1=hold[7:0], valid=1, then return to ACTIVE_HI. Entered only from ACTIVE_HI; never idles mid-word.
- active_out=1 in ACTIVE_HI/ACTIVE_LO, registered with the state.
- Latency: a word accepted at edge E into an empty FIFO in ACTIVE drives its high half after edge E+1 and its low half after edge E+2.
- Throughput is 1 word per 2 cycles. Sustained valid_in fills the FIFO, and ready_out then drops. Consecutive words are sent with no IDLE gap.
- Both lanes always carry the same symbol class in a cycle, so valid_out_0 equals valid_out_1.
- Reset asserted mid-word: the partially sent word and all buffered words are discarded. Training restarts on release.

Test Plan:
- Reset release, no input -> SYNC_COUNT(8) cycles of 0xBC/0xBC with valid=1, then 0x7C/0x7C with valid=0, active_out rises on cycle 9.
- Single word 32'hA1B2C3D4 after training -> lanes A1/B2, then C3/D4, valid=1 on both cycles, then 7C/7C with valid=0. First half appears one cycle after acceptance.
- Three words sent during SYNC -> all held. After training they appear back-to-back as 6 data cycles with no idle between them.
- valid_in held high with 8 distinct words -> ready_out drops when count=4, resumes as words drain. All 8 words arrive in order and complete, with none lost or duplicated.
- Pointer wrap: 10 words with random gaps -> output order matches input order across two pointer wraps.
- reset pulled low during ACTIVE_LO of word 32'h11223344 -> outputs go to 00/valid 0 immediately. After release, SYNC repeats, 33/44 is never emitted and the FIFO is empty.

Source files
------------

// File: rtl/phy_tx_lane_striper_if.sv
// rtl/phy_tx_lane_striper_if.sv - link-layer word input and two-lane PHY output bundle
interface phy_tx_lane_striper_if;
    logic [31:0] data_in;
    logic        valid_in;
    logic        ready_out;
    logic [7:0]  data_out_0;
    logic [7:0]  data_out_1;
    logic        valid_out_0;
    logic        valid_out_1;
    logic        active_out;

    // link-layer side: offers words, watches the lanes
    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  data_out_0,
        input  data_out_1,
        input  valid_out_0,
        input  valid_out_1,
        input  active_out
    );

    // striper side: accepts words, drives the lanes
    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output data_out_0,
        output data_out_1,
        output valid_out_0,
        output valid_out_1,
        output active_out
    );
endinterface

// File: rtl/phy_tx_lane_striper.sv
// rtl/phy_tx_lane_striper.sv - buffers 32-bit words and stripes them over two byte lanes after COM training
module phy_tx_lane_striper #(
    parameter int         FIFO_DEPTH = 4,
    parameter int         SYNC_COUNT = 8,
    parameter logic [7:0] COM_SYM    = 8'hBC,
    parameter logic [7:0] IDLE_SYM   = 8'h7C
) (
    input  logic                    clk_2f,
    input  logic                    reset,
    phy_tx_lane_striper_if.slave    bus
);

    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int SYNC_W = (SYNC_COUNT > 1) ? $clog2(SYNC_COUNT) : 1;

    typedef enum logic [1:0] {
        SYNC      = 2'd0,
        ACTIVE_HI = 2'd1,
        ACTIVE_LO = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [31:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic [SYNC_W-1:0]  r_sync_cnt;
    logic [SYNC_W-1:0]  w_sync_cnt_nxt;
    logic [31:0]        r_hold;

    logic [7:0]         r_d0;
    logic [7:0]         r_d1;
    logic               r_valid;
    logic               r_active;

    logic               w_ready;
    logic               w_push;
    logic               w_pop;
    logic [31:0]        w_head;
    logic [7:0]         w_d0_nxt;
    logic [7:0]         w_d1_nxt;
    logic               w_valid_nxt;

    // Space is judged on the current count only; a same-cycle pop never frees a slot early.
    assign w_ready = (r_count != CNT_W'(FIFO_DEPTH));
    assign w_push  = bus.valid_in && w_ready;
    assign w_head  = r_mem[r_rd_ptr];

    assign bus.ready_out   = w_ready;
    assign bus.data_out_0  = r_d0;
    assign bus.data_out_1  = r_d1;
    assign bus.valid_out_0 = r_valid;
    assign bus.valid_out_1 = r_valid;
    assign bus.active_out  = r_active;

    // Word storage: written on accept, no reset needed since the count guards every read.
    always_ff @(posedge clk_2f) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Next state and the lane symbols that state produces on the coming edge.
    always_comb begin
        w_state_nxt    = r_state;
        w_sync_cnt_nxt = r_sync_cnt;
        w_pop          = 1'b0;
        w_d0_nxt       = IDLE_SYM;
        w_d1_nxt       = IDLE_SYM;
        w_valid_nxt    = 1'b0;
        case (r_state)
            SYNC: begin
                w_d0_nxt    = COM_SYM;
                w_d1_nxt    = COM_SYM;
                w_valid_nxt = 1'b1;
                if (r_sync_cnt == SYNC_W'(SYNC_COUNT - 1)) begin
                    w_sync_cnt_nxt = '0;
                    w_state_nxt    = ACTIVE_HI;
                end else begin
                    w_sync_cnt_nxt = r_sync_cnt + SYNC_W'(1);
                end
            end
            ACTIVE_HI: begin
                if (r_count != '0) begin
                    w_pop       = 1'b1;
                    w_d0_nxt    = w_head[31:24];
                    w_d1_nxt    = w_head[23:16];
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ACTIVE_LO;
                end
            end
            ACTIVE_LO: begin
                w_d0_nxt    = r_hold[15:8];
                w_d1_nxt    = r_hold[7:0];
                w_valid_nxt = 1'b1;
                w_state_nxt = ACTIVE_HI;
            end
            default: begin
                w_state_nxt = SYNC;
            end
        endcase
    end

    // State, training counter, hold register and registered lane outputs.
    // active_out tracks the state that produced the current lane symbols, so it
    // rises together with the first post-training symbol.
    always_ff @(posedge clk_2f or negedge reset) begin
        if (!reset) begin
            r_state    <= SYNC;
            r_sync_cnt <= '0;
            r_hold     <= '0;
            r_d0       <= 8'h00;
            r_d1       <= 8'h00;
            r_valid    <= 1'b0;
            r_active   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sync_cnt <= w_sync_cnt_nxt;
            if (w_pop) begin
                r_hold <= w_head;
            end
            r_d0       <= w_d0_nxt;
            r_d1       <= w_d1_nxt;
            r_valid    <= w_valid_nxt;
            r_active   <= (r_state != SYNC);
        end
    end

endmodule

// File: tb/tb_phy_tx_lane_striper.sv
// tb/tb_phy_tx_lane_striper.sv - scoreboard bench for the two-lane transmit striper
module tb_phy_tx_lane_striper;

    localparam logic [7:0] COM  = 8'hBC;
    localparam logic [7:0] IDLE = 8'h7C;

    typedef struct packed {
        logic [7:0] d0;
        logic [7:0] d1;
    } pair_t;

    logic clk_2f;
    logic reset;
    phy_tx_lane_striper_if bus ();

    int    n_assert;
    int    n_fail;
    int    stalls;
    logic  mon_lo;
    pair_t sb [$];

    phy_tx_lane_striper #(
        .FIFO_DEPTH (4),
        .SYNC_COUNT (8),
        .COM_SYM    (8'hBC),
        .IDLE_SYM   (8'h7C)
    ) dut (
        .clk_2f (clk_2f),
        .reset  (reset),
        .bus    (bus)
    );

    initial clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic lanes(input string name, input logic [7:0] e0, input logic [7:0] e1,
                         input logic ev, input logic ea);
        check(name,
              {13'b0, bus.data_out_0, bus.data_out_1, bus.valid_out_0, bus.valid_out_1, bus.active_out},
              {13'b0, e0, e1, ev, ev, ea});
    endtask

    // Offer a word now (caller is away from a rising edge); return just after it is accepted.
    task automatic send_word(input logic [31:0] w);
        int k;
        bus.data_in  = w;
        bus.valid_in = 1'b1;
        k = 0;
        while (!bus.ready_out && k < 100) begin
            @(negedge clk_2f);
            stalls++;
            k++;
        end
        if (k == 100) check("send_timeout", 32'(k), 0);
        sb.push_back('{w[31:24], w[23:16]});
        sb.push_back('{w[15:8], w[7:0]});
        @(posedge clk_2f);
        #1;
        bus.valid_in = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(negedge clk_2f);
            k++;
        end
        check(name, 32'(sb.size()), 0);
        @(negedge clk_2f);
        lanes({name, "_idle"}, IDLE, IDLE, 1'b0, 1'b1);
    endtask

    task automatic training(input string name, input int first);
        for (int c = first; c <= 8; c++) begin
            @(negedge clk_2f);
            lanes($sformatf("%s_com%0d", name, c), COM, COM, 1'b1, 1'b0);
        end
    endtask

    // Monitor: every active data symbol pair must be the next scoreboard entry.
    always @(negedge clk_2f) begin
        if (!reset) begin
            mon_lo = 1'b0;
        end else if (bus.active_out) begin
            check("lane_valid_match", {31'b0, bus.valid_out_1}, {31'b0, bus.valid_out_0});
            if (mon_lo) check("no_idle_mid_word", {31'b0, bus.valid_out_0}, 32'd1);
            if (bus.valid_out_0) begin
                if (sb.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %h%h expected nothing", bus.data_out_0, bus.data_out_1);
                end else begin
                    pair_t e;
                    e = sb.pop_front();
                    check("sb_data", {16'b0, bus.data_out_0, bus.data_out_1}, {16'b0, e.d0, e.d1});
                end
                mon_lo = ~mon_lo;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] hold3 [3];
        n_assert     = 0;
        n_fail       = 0;
        stalls       = 0;
        mon_lo       = 1'b0;
        reset        = 1'b0;
        bus.data_in  = '0;
        bus.valid_in = 1'b0;

        // Reset state and training burst
        repeat (3) @(negedge clk_2f);
        lanes("reset_lanes", 8'h00, 8'h00, 1'b0, 1'b0);
        check("reset_ready", {31'b0, bus.ready_out}, 32'd1);
        reset = 1'b1;
        training("t1", 1);
        @(negedge clk_2f);
        lanes("t1_first_idle", IDLE, IDLE, 1'b0, 1'b1);
        @(negedge clk_2f);
        lanes("t1_idle2", IDLE, IDLE, 1'b0, 1'b1);

        // Single word: high half one cycle after acceptance
        send_word(32'hA1B2C3D4);
        @(negedge clk_2f);
        lanes("w1_accept_idle", IDLE, IDLE, 1'b0, 1'b1);
        @(negedge clk_2f);
        lanes("w1_hi", 8'hA1, 8'hB2, 1'b1, 1'b1);
        @(negedge clk_2f);
        lanes("w1_lo", 8'hC3, 8'hD4, 1'b1, 1'b1);
        @(negedge clk_2f);
        lanes("w1_after", IDLE, IDLE, 1'b0, 1'b1);

        // Three words accepted during SYNC come out back-to-back
        #1;
        reset = 1'b0;
        sb.delete();
        #1;
        lanes("rst2_lanes", 8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk_2f);
        @(negedge clk_2f);
        reset = 1'b1;
        hold3[0] = 32'hDEADBEEF;
        hold3[1] = 32'h01234567;
        hold3[2] = 32'h89ABCDEF;
        for (int i = 0; i < 3; i++) send_word(hold3[i]);
        training("t2", 3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_2f);
            lanes($sformatf("sync_w%0d_hi", i), hold3[i][31:24], hold3[i][23:16], 1'b1, 1'b1);
            @(negedge clk_2f);
            lanes($sformatf("sync_w%0d_lo", i), hold3[i][15:8], hold3[i][7:0], 1'b1, 1'b1);
        end
        @(negedge clk_2f);
        lanes("sync_words_done", IDLE, IDLE, 1'b0, 1'b1);

        // Sustained valid_in: FIFO fills and ready_out drops
        stalls = 0;
        for (int i = 0; i < 8; i++) send_word(32'h0A0B0C00 | 32'(i * 17));
        check("ready_dropped", {31'b0, (stalls > 0)}, 32'd1);
        wait_drain("drain_burst");

        // Pointer wrap with random gaps
        for (int i = 0; i < 10; i++) begin
            send_word(32'h50000000 + 32'(i) * 32'h00010203);
            repeat ($urandom_range(0, 4)) #10;
        end
        wait_drain("drain_wrap");

        // Reset in the middle of a word discards it and the buffered word
        send_word(32'h11223344);
        send_word(32'h55667788);
        @(negedge clk_2f);
        lanes("mid_hi", 8'h11, 8'h22, 1'b1, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        lanes("mid_reset_lanes", 8'h00, 8'h00, 1'b0, 1'b0);
        check("mid_reset_ready", {31'b0, bus.ready_out}, 32'd1);
        sb.delete();
        @(negedge clk_2f);
        @(negedge clk_2f);
        reset = 1'b1;
        training("t3", 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_2f);
            lanes($sformatf("post_reset_idle%0d", i), IDLE, IDLE, 1'b0, 1'b1);
        end

        check("final_sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
